// File: rtl/yolo_class_max_ctrl.sv
// yolo_class_max_ctrl: feeds one grid cell's class scores (NUM_GROUPS words of
// five 8-class anchors) through the external 1x8 comparator bank, follows the
// bank latency with a tag pipe, and reduces the per-group maxima into a global
// max score and class index per anchor, presented on a valid/ready output.
module yolo_class_max_ctrl #(
    parameter int NUM_GROUPS = 10,
    parameter int CMP_LAT    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         yolo_layer_finish,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] in_data,
    output logic [63:0]  pc1,
    output logic [63:0]  pc2,
    output logic [63:0]  pc3,
    output logic [63:0]  pc4,
    output logic [63:0]  pc5,
    output logic         cmp_finish,
    input  logic [7:0]   cmax8_value_1,
    input  logic [7:0]   cmax8_value_2,
    input  logic [7:0]   cmax8_value_3,
    input  logic [7:0]   cmax8_value_4,
    input  logic [7:0]   cmax8_value_5,
    input  logic [2:0]   cmax8_index_1,
    input  logic [2:0]   cmax8_index_2,
    input  logic [2:0]   cmax8_index_3,
    input  logic [2:0]   cmax8_index_4,
    input  logic [2:0]   cmax8_index_5,
    output logic         cls_valid,
    input  logic         cls_ready,
    output logic [39:0]  cls_value,
    output logic [34:0]  cls_index,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    // Group numbers are 4 bits wide so that {group, byte index} is the 7-bit class index.
    localparam logic [3:0] LAST_GROUP = 4'(NUM_GROUPS - 1);

    state_t                r_state;
    state_t                w_nextState;
    logic [3:0]            r_group;
    logic [4:0][63:0]      r_pc;
    logic [CMP_LAT:0]      r_tagValid;
    logic [CMP_LAT:0][3:0] r_tagGroup;
    logic [4:0][7:0]       r_maxVal;
    logic [4:0][6:0]       r_maxIdx;

    logic [4:0][7:0]       w_cmaxVal;
    logic [4:0][2:0]       w_cmaxIdx;
    logic                  w_accept;
    logic                  w_sample;
    logic [3:0]            w_sampleGroup;
    logic                  w_lastSample;

    assign w_cmaxVal = {cmax8_value_5, cmax8_value_4, cmax8_value_3, cmax8_value_2, cmax8_value_1};
    assign w_cmaxIdx = {cmax8_index_5, cmax8_index_4, cmax8_index_3, cmax8_index_2, cmax8_index_1};

    // A layer abort overrides the handshake, so no word is taken in that cycle.
    assign w_accept      = (r_state == FEED) && in_valid && !yolo_layer_finish;
    assign w_sample      = r_tagValid[CMP_LAT];
    assign w_sampleGroup = r_tagGroup[CMP_LAT];
    assign w_lastSample  = w_sample && (w_sampleGroup == LAST_GROUP);

    // State register; layer abort returns to IDLE through the next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: feed all groups, wait for the last tag, then hold the result.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = FEED;
            FEED:    if (w_accept && (r_group == LAST_GROUP)) w_nextState = DRAIN;
            DRAIN:   if (w_lastSample) w_nextState = DONE;
            DONE:    if (cls_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (yolo_layer_finish) begin
            w_nextState = IDLE;
        end
    end

    // Operand registers, group counter, latency tag pipe and running max per anchor.
    always_ff @(posedge clk) begin
        if (rst || yolo_layer_finish) begin
            r_group    <= '0;
            r_pc       <= '0;
            r_tagValid <= '0;
            r_tagGroup <= '0;
            r_maxVal   <= '0;
            r_maxIdx   <= '0;
        end else begin
            r_tagValid <= {r_tagValid[CMP_LAT-1:0], w_accept};
            r_tagGroup <= {r_tagGroup[CMP_LAT-1:0], r_group};
            if ((r_state == IDLE) && start) begin
                r_group    <= '0;
                r_tagValid <= '0;
            end
            if (w_accept) begin
                r_pc    <= in_data;
                r_group <= r_group + 4'd1;
            end
            if (w_sample) begin
                for (int k = 0; k < 5; k++) begin
                    if ((w_sampleGroup == 4'd0) || (w_cmaxVal[k] > r_maxVal[k])) begin
                        r_maxVal[k] <= w_cmaxVal[k];
                        r_maxIdx[k] <= {w_sampleGroup, w_cmaxIdx[k]};
                    end
                end
            end
        end
    end

    assign in_ready   = (r_state == FEED);
    assign cls_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign cmp_finish = rst | yolo_layer_finish;
    assign pc1        = r_pc[0];
    assign pc2        = r_pc[1];
    assign pc3        = r_pc[2];
    assign pc4        = r_pc[3];
    assign pc5        = r_pc[4];
    assign cls_value  = r_maxVal;
    assign cls_index  = r_maxIdx;

endmodule

// File: tb/tb_yolo_class_max_ctrl.sv
// tb_yolo_class_max_ctrl: drives two controller instances (default sizing and a
// one-group/one-cycle-latency variant), each with a behavioural comparator bank,
// and compares results against a flat argmax reference over all class scores.
module tb_yolo_class_max_ctrl;

    localparam int A_NG  = 10;
    localparam int A_LAT = 2;
    localparam int B_NG  = 1;
    localparam int B_LAT = 1;

    logic clk;
    logic rst;
    int   cyc;
    int   testCount;
    int   failCount;

    logic [7:0] sc [5][128];

    logic         aFinish, aStart, aValid, aInReady, aCmpFinish, aClsValid, aClsReady, aBusy;
    logic [319:0] aData;
    logic [63:0]  aPc1, aPc2, aPc3, aPc4, aPc5;
    logic [39:0]  aClsValue;
    logic [34:0]  aClsIndex;
    logic [54:0]  aBank [A_LAT];
    logic [54:0]  aBankOut;

    logic         bFinish, bStart, bValid, bInReady, bCmpFinish, bClsValid, bClsReady, bBusy;
    logic [319:0] bData;
    logic [63:0]  bPc1, bPc2, bPc3, bPc4, bPc5;
    logic [39:0]  bClsValue;
    logic [34:0]  bClsIndex;
    logic [54:0]  bBank [B_LAT];
    logic [54:0]  bBankOut;

    yolo_class_max_ctrl #(.NUM_GROUPS(A_NG), .CMP_LAT(A_LAT)) dutA (
        .clk(clk), .rst(rst), .yolo_layer_finish(aFinish), .start(aStart),
        .in_valid(aValid), .in_ready(aInReady), .in_data(aData),
        .pc1(aPc1), .pc2(aPc2), .pc3(aPc3), .pc4(aPc4), .pc5(aPc5),
        .cmp_finish(aCmpFinish),
        .cmax8_value_1(aBankOut[3 +: 8]),  .cmax8_value_2(aBankOut[14 +: 8]),
        .cmax8_value_3(aBankOut[25 +: 8]), .cmax8_value_4(aBankOut[36 +: 8]),
        .cmax8_value_5(aBankOut[47 +: 8]),
        .cmax8_index_1(aBankOut[0 +: 3]),  .cmax8_index_2(aBankOut[11 +: 3]),
        .cmax8_index_3(aBankOut[22 +: 3]), .cmax8_index_4(aBankOut[33 +: 3]),
        .cmax8_index_5(aBankOut[44 +: 3]),
        .cls_valid(aClsValid), .cls_ready(aClsReady), .cls_value(aClsValue),
        .cls_index(aClsIndex), .busy(aBusy)
    );

    yolo_class_max_ctrl #(.NUM_GROUPS(B_NG), .CMP_LAT(B_LAT)) dutB (
        .clk(clk), .rst(rst), .yolo_layer_finish(bFinish), .start(bStart),
        .in_valid(bValid), .in_ready(bInReady), .in_data(bData),
        .pc1(bPc1), .pc2(bPc2), .pc3(bPc3), .pc4(bPc4), .pc5(bPc5),
        .cmp_finish(bCmpFinish),
        .cmax8_value_1(bBankOut[3 +: 8]),  .cmax8_value_2(bBankOut[14 +: 8]),
        .cmax8_value_3(bBankOut[25 +: 8]), .cmax8_value_4(bBankOut[36 +: 8]),
        .cmax8_value_5(bBankOut[47 +: 8]),
        .cmax8_index_1(bBankOut[0 +: 3]),  .cmax8_index_2(bBankOut[11 +: 3]),
        .cmax8_index_3(bBankOut[22 +: 3]), .cmax8_index_4(bBankOut[33 +: 3]),
        .cmax8_index_5(bBankOut[44 +: 3]),
        .cls_valid(bClsValid), .cls_ready(bClsReady), .cls_value(bClsValue),
        .cls_index(bClsIndex), .busy(bBusy)
    );

    // Comparator bank behaviour: max byte of each 64-bit operand, lowest byte on ties.
    function automatic logic [54:0] bankOf(input logic [319:0] w);
        logic [54:0] r;
        logic [7:0]  best;
        logic [2:0]  bi;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            best = w[64*k +: 8];
            bi   = 3'd0;
            for (int j = 1; j < 8; j++) begin
                if (w[64*k + 8*j +: 8] > best) begin
                    best = w[64*k + 8*j +: 8];
                    bi   = 3'(j);
                end
            end
            r[11*k +: 11] = {best, bi};
        end
        return r;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank latency pipes for both instances.
    always @(posedge clk) begin
        aBank[0] <= bankOf({aPc5, aPc4, aPc3, aPc2, aPc1});
        for (int i = 1; i < A_LAT; i++) aBank[i] <= aBank[i-1];
        bBank[0] <= bankOf({bPc5, bPc4, bPc3, bPc2, bPc1});
        for (int i = 1; i < B_LAT; i++) bBank[i] <= bBank[i-1];
    end
    assign aBankOut = aBank[A_LAT-1];
    assign bBankOut = bBank[B_LAT-1];

    // Global run bound so the bench always terminates.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: flat argmax over all classes of each anchor, lowest class wins ties.
    function automatic void refModel(input int ng, output logic [39:0] v, output logic [34:0] ix);
        int bestC;
        v  = '0;
        ix = '0;
        for (int k = 0; k < 5; k++) begin
            bestC = 0;
            for (int c = 1; c < ng*8; c++) begin
                if (sc[k][c] > sc[k][bestC]) bestC = c;
            end
            v[8*k +: 8]  = sc[k][bestC];
            ix[7*k +: 7] = 7'(bestC);
        end
    endfunction

    function automatic logic [319:0] wordOf(input int g);
        logic [319:0] w;
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 8; j++)
                w[64*k + 8*j +: 8] = sc[k][8*g + j];
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic fillConst(input logic [7:0] v);
        for (int k = 0; k < 5; k++)
            for (int c = 0; c < 128; c++) sc[k][c] = v;
    endtask

    task automatic fillRandom(input int maxVal);
        for (int k = 0; k < 5; k++)
            for (int c = 0; c < 128; c++) sc[k][c] = 8'($urandom_range(0, maxVal));
    endtask

    // One cell on instance A. mode 0: in_valid constant, 1: toggling, 2: random.
    // hold: cycles cls_ready stays low in DONE with start pulsing. expLat < 0 skips latency.
    task automatic applyStimulus(input int mode, input int hold, input int expLat);
        logic [39:0]  ev;
        logic [34:0]  ei;
        logic [319:0] junk;
        int           s;
        int           accepts;
        int           wIdx;
        bit           got;
        refModel(A_NG, ev, ei);
        s       = cyc;
        accepts = 0;
        wIdx    = 0;
        got     = 1'b0;
        aStart  = 1'b1;
        aValid  = 1'b1;
        aData   = wordOf(0);
        tick;
        aStart  = 1'b0;
        for (int n = 0; n < 120 && !got; n++) begin
            if (aClsValid) begin
                got = 1'b1;
            end else begin
                case (mode)
                    0:       aValid = 1'b1;
                    1:       aValid = (((cyc - s) % 2) == 0);
                    default: aValid = 1'($urandom_range(0, 1));
                endcase
                if (wIdx < A_NG) begin
                    aData = wordOf(wIdx);
                end else begin
                    for (int i = 0; i < 10; i++) junk[32*i +: 32] = $urandom;
                    aData = junk;
                end
                if (aValid && aInReady) begin
                    accepts++;
                    wIdx++;
                end
                tick;
            end
        end
        aValid = 1'b0;
        checkOutput("clsValidSeen", 64'(got), 64'd1);
        if (expLat >= 0) checkOutput("latency", 64'(cyc - s), 64'(expLat));
        checkOutput("accepts", 64'(accepts), 64'(A_NG));
        checkOutput("doneInReady", 64'(aInReady), 64'd0);
        checkOutput("clsValue", 64'(aClsValue), 64'(ev));
        checkOutput("clsIndex", 64'(aClsIndex), 64'(ei));
        for (int h = 0; h < hold; h++) begin
            aStart = 1'b1;
            tick;
            aStart = 1'b0;
            checkOutput("holdValid", 64'(aClsValid), 64'd1);
            checkOutput("holdValue", 64'(aClsValue), 64'(ev));
            checkOutput("holdIndex", 64'(aClsIndex), 64'(ei));
        end
        aClsReady = 1'b1;
        tick;
        aClsReady = 1'b0;
        checkOutput("idleBusy", 64'(aBusy), 64'd0);
        checkOutput("idleValid", 64'(aClsValid), 64'd0);
    endtask

    initial begin
        logic [39:0] ev;
        logic [34:0] ei;
        int          s;
        int          wIdx;
        bit          got;
        bit          sawValid;

        cyc = 0; testCount = 0; failCount = 0;
        rst = 1'b1;
        aFinish = 0; aStart = 0; aValid = 0; aClsReady = 0; aData = '0;
        bFinish = 0; bStart = 0; bValid = 0; bClsReady = 0; bData = '0;
        repeat (3) tick;

        checkOutput("rstCmpFinishA", 64'(aCmpFinish), 64'd1);
        checkOutput("rstCmpFinishB", 64'(bCmpFinish), 64'd1);
        rst = 1'b0;
        tick;
        checkOutput("rstBusy", 64'(aBusy), 64'd0);
        checkOutput("rstInReady", 64'(aInReady), 64'd0);
        checkOutput("rstClsValid", 64'(aClsValid), 64'd0);
        checkOutput("rstPc1", aPc1, 64'd0);
        checkOutput("rstClsValue", 64'(aClsValue), 64'd0);
        checkOutput("rstClsIndex", 64'(aClsIndex), 64'd0);
        checkOutput("rstCmpFinishOff", 64'(aCmpFinish), 64'd0);
        checkOutput("rstBusyB", 64'(bBusy), 64'd0);

        $display("[TB] default pattern, constant in_valid");
        fillConst(8'h10);
        sc[0][37] = 8'hF0;
        applyStimulus(0, 0, 14);

        $display("[TB] tie on anchor 3, held in DONE with start pulses");
        fillConst(8'h00);
        sc[2][5]  = 8'hFF;
        sc[2][61] = 8'hFF;
        applyStimulus(0, 5, 14);

        $display("[TB] all-zero scores");
        fillConst(8'h00);
        applyStimulus(0, 0, 14);

        $display("[TB] default pattern, toggling in_valid");
        fillConst(8'h10);
        sc[0][37] = 8'hF0;
        applyStimulus(1, 0, 24);

        $display("[TB] layer abort after four accepts");
        fillRandom(255);
        aStart = 1'b1;
        aValid = 1'b1;
        aData  = wordOf(0);
        tick;
        aStart = 1'b0;
        wIdx   = 0;
        for (int n = 0; n < 20 && wIdx < 4; n++) begin
            aData = wordOf(wIdx);
            if (aInReady) wIdx++;
            tick;
        end
        checkOutput("abortAccepts", 64'(wIdx), 64'd4);
        aData   = wordOf(4);
        aFinish = 1'b1;
        #1;
        checkOutput("abortCmpFinish", 64'(aCmpFinish), 64'd1);
        tick;
        aFinish = 1'b0;
        aValid  = 1'b0;
        checkOutput("abortBusy", 64'(aBusy), 64'd0);
        checkOutput("abortInReady", 64'(aInReady), 64'd0);
        checkOutput("abortClsValid", 64'(aClsValid), 64'd0);
        checkOutput("abortPc1", aPc1, 64'd0);
        checkOutput("abortPc5", aPc5, 64'd0);
        checkOutput("abortClsValue", 64'(aClsValue), 64'd0);
        checkOutput("abortClsIndex", 64'(aClsIndex), 64'd0);
        sawValid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick;
            if (aClsValid) sawValid = 1'b1;
        end
        checkOutput("abortNoResult", 64'(sawValid), 64'd0);
        fillRandom(255);
        applyStimulus(0, 0, 14);

        $display("[TB] randomized cells");
        for (int r = 0; r < 6; r++) begin
            fillRandom((r % 2 == 0) ? 255 : 3);
            applyStimulus(r % 3, (r == 4) ? 2 : 0, (r % 3 == 0) ? 14 : ((r % 3 == 1) ? 24 : -1));
        end

        $display("[TB] one group, latency one");
        fillRandom(191);
        sc[0][7] = 8'hF0;
        refModel(B_NG, ev, ei);
        s      = cyc;
        got    = 1'b0;
        bStart = 1'b1;
        bValid = 1'b1;
        bData  = wordOf(0);
        tick;
        bStart = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (bClsValid) got = 1'b1;
            else tick;
        end
        bValid = 1'b0;
        checkOutput("bValidSeen", 64'(got), 64'd1);
        checkOutput("bLatency", 64'(cyc - s), 64'd4);
        checkOutput("bIndex1", 64'(bClsIndex[6:0]), 64'd7);
        checkOutput("bClsValue", 64'(bClsValue), 64'(ev));
        checkOutput("bClsIndex", 64'(bClsIndex), 64'(ei));
        bClsReady = 1'b1;
        tick;
        bClsReady = 1'b0;
        checkOutput("bIdleBusy", 64'(bBusy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/yolo_class_max_ctrl.md
# yolo_class_max_ctrl

Sequencer for the five-anchor 1x8 class comparator bank in the YOLO layer. For one grid cell it streams NUM_GROUPS 8-class score words per anchor into the bank and tracks the bank's fixed latency. It reduces the per-group maxima into a global maximum class score and a class index per anchor, then presents the five results on a valid/ready output. It sits between the class-score buffer reader and the box-decode stage.

## Interface
Parameters:
- NUM_GROUPS, 10, 8-class groups per anchor (80 classes); legal range 1..16
- CMP_LAT, 2, comparator bank latency in cycles from pcX change to matching cmax8 output; legal range 1..4

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- yolo_layer_finish  in  1  synchronous abort/clear for the layer
- start  in  1  one-cycle pulse; begin one cell (ignored unless IDLE)
- in_valid  in  1  score word available
- in_ready  out  1  controller accepts word
- in_data  in  320  five 64-bit words; [64k+63:64k] = anchor k+1, byte j = class 8g+j
- pc1..pc5  out  64 each  registered operands to comparator bank
- cmp_finish  out  1  drives the bank's yolo_layer_finish; equals rst | yolo_layer_finish (combinational)
- cmax8_value_1..5  in  8 each  bank max value per anchor
- cmax8_index_1..5  in  3 each  bank max index per anchor
- cls_valid  out  1  result valid
- cls_ready  in  1  downstream accepts result
- cls_value  out  40  byte k = max score of anchor k+1
- cls_index  out  35  bits [7k+6:7k] = global class index of anchor k+1
- busy  out  1  high in any state but IDLE

## Operation
- FSM: IDLE, FEED, DRAIN, DONE.
- IDLE: start=1 -> FEED; group counter g=0; pipeline cleared.
- FEED: in_ready=1. On in_valid&in_ready, in_data is registered into pc1..pc5, and a tag (valid, group g) enters a CMP_LAT+1 deep shift pipe; g increments. After accept of group NUM_GROUPS-1 -> DRAIN. in_ready is 0 in all other states.
- pcX hold their last value when no word is accepted.
- Sampling: when the pipe output tag is valid, read cmax8_value_k/index_k. Global index = g*8 + cmax8_index_k (7-bit unsigned).
- Group 0 result loads the running max unconditionally. Later groups replace it only if the value is strictly greater (unsigned 8-bit compare), so on ties the lower class index wins.
- DRAIN: wait until the tag of the last group has been sampled, then DONE.
- DONE: cls_valid=1; cls_value and cls_index are stable. cls_valid&cls_ready -> IDLE.
- yolo_layer_finish=1, any state: next state IDLE; pipe tags and cls_valid cleared; no result is emitted. It takes priority over start and over all handshakes in the same cycle.
- start while busy is ignored.

## Timing
- Reset, and the cycle after yolo_layer_finish: state IDLE, in_ready=0, cls_valid=0, busy=0, pc1..pc5=0, cls_value=0, cls_index=0, g=0.
- Word accepted in cycle t -> on pcX in t+1 -> sampled in t+1+CMP_LAT.
- start in cycle s with in_valid held high: words accepted s+1..s+NUM_GROUPS, cls_valid first high in s+NUM_GROUPS+CMP_LAT+2. With defaults that is s+14.
- Gaps in in_valid stretch FEED. The pipe shifts every cycle, so bubbles carry invalid tags.
- cls_valid holds until cls_ready. The earliest next start is accepted the cycle after the handshake (back in IDLE).
- busy registered; rises the cycle after start.

## Test plan
- Defaults. Anchor 1 class 37 = 0xF0, all other scores 0x10, in_valid constant -> cls_valid at s+14, cls_index[6:0]=37, cls_value[7:0]=0xF0; other anchors report index 0, value 0x10.
- Tie: anchor 3 classes 5 and 61 both 0xFF, rest 0x00 -> index 5, value 0xFF. All-zero scores -> every index 0, value 0x00.
- in_valid toggling 1/0 every cycle -> exactly 10 accepts, same result as the constant stream, cls_valid at s+24.
- cls_ready held low 5 cycles in DONE -> cls_valid and data stable; start pulses during DONE ignored; IDLE the cycle after the cls_ready handshake.
- yolo_layer_finish pulsed mid-FEED after 4 accepts -> IDLE next cycle, in_ready=0, cmp_finish=1 that cycle, no cls_valid. A new start then produces a correct result uncorrupted by earlier groups.
- NUM_GROUPS=1, CMP_LAT=1: single word with max at byte 7 -> index 7, cls_valid at s+4.
